// File: rtl/matrixops_feeder.sv
// Frame buffer in front of matrixops: collects host (x, y, last) pairs and replays each complete
// frame as an unbroken enter/X/Y burst, with a fixed idle gap after every frame.
module matrixops_feeder #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned GAP   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [1:0]               wr_x,
  input  logic [1:0]               wr_y,
  input  logic                     wr_last,
  output logic                     enter,
  output logic [1:0]               X,
  output logic [1:0]               Y,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   frames_pending,
  output logic                     err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned GW = (GAP > 1) ? $clog2(GAP) : 1;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StSend = 2'd1;
  localparam logic [1:0] StGap  = 2'd2;

  logic [1:0] mem_x    [DEPTH];
  logic [1:0] mem_y    [DEPTH];
  logic       mem_last [DEPTH];

  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic [AW:0]   fp_q, fp_d;
  logic [1:0]    state_q, state_d;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;
  logic          enter_q, last_q, busy_q, err_q;
  logic [1:0]    x_q, y_q;

  logic full, start, pop, push, overflow, ready;

  always_comb begin
    full      = (count_q == (AW + 1)'(DEPTH));
    start     = 1'b0;
    pop       = 1'b0;
    state_d   = state_q;
    gap_cnt_d = gap_cnt_q;
    case (state_q)
      StIdle: begin
        if (fp_q != '0) begin
          start   = 1'b1;
          state_d = StSend;
        end
      end
      StSend: begin
        // last_q marks that the entry now on the bus closed the frame
        if (last_q) begin
          state_d   = StGap;
          gap_cnt_d = GW'(GAP - 1);
        end else begin
          pop = 1'b1;
        end
      end
      StGap: begin
        if (gap_cnt_q == '0) begin
          if (fp_q != '0) begin
            start   = 1'b1;
            state_d = StSend;
          end else begin
            state_d = StIdle;
          end
        end else begin
          gap_cnt_d = gap_cnt_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    pop = pop | start;

    // Full with no complete frame means a frame cannot fit; entries of a frame still being
    // sent are exempt since they drain on their own.
    overflow = full && (fp_q == '0) && !(state_q == StSend && !last_q);
    ready    = !full || pop;
    push     = wr_valid && ready;

    count_d = count_q;
    if (push && !pop) count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;

    fp_d = fp_q;
    if ((push && wr_last) && !start) fp_d = fp_q + 1'b1;
    else if (start && !(push && wr_last)) fp_d = fp_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_x[wr_ptr_q]    <= wr_x;
      mem_y[wr_ptr_q]    <= wr_y;
      mem_last[wr_ptr_q] <= wr_last;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      fp_q      <= '0;
      state_q   <= StIdle;
      gap_cnt_q <= '0;
      enter_q   <= 1'b0;
      last_q    <= 1'b0;
      x_q       <= 2'd0;
      y_q       <= 2'd0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      if (overflow) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
        err_q    <= 1'b1;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        count_q <= count_d;
      end
      fp_q      <= fp_d;
      state_q   <= state_d;
      gap_cnt_q <= gap_cnt_d;
      enter_q   <= pop;
      x_q       <= pop ? mem_x[rd_ptr_q] : 2'd0;
      y_q       <= pop ? mem_y[rd_ptr_q] : 2'd0;
      last_q    <= pop ? mem_last[rd_ptr_q] : 1'b0;
      busy_q    <= (state_d != StIdle);
    end
  end

  assign wr_ready       = ready;
  assign enter          = enter_q;
  assign X              = x_q;
  assign Y              = y_q;
  assign busy           = busy_q;
  assign frames_pending = fp_q;
  assign err            = err_q;

endmodule

// File: tb/tb_matrixops_feeder.sv
// Directed bench for matrixops_feeder: instance a (DEPTH=16, GAP=2) and b (DEPTH=4, GAP=1)
// share stimulus; each test checks the instance it targets.
module tb_matrixops_feeder;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wr_valid = 1'b0;
  logic       wr_last = 1'b0;
  logic [1:0] wr_x = 2'd0;
  logic [1:0] wr_y = 2'd0;

  logic       a_wr_ready, a_enter, a_busy, a_err;
  logic [1:0] a_x, a_y;
  logic [4:0] a_fp;
  logic       b_wr_ready, b_enter, b_busy, b_err;
  logic [1:0] b_x, b_y;
  logic [2:0] b_fp;

  int n_cmp = 0;
  int n_bad = 0;

  logic [1:0] fx [8];
  logic [1:0] fy [8];
  logic [1:0] px [8];
  logic [1:0] py [8];
  logic [1:0] qx [6];
  logic [1:0] qy [6];

  matrixops_feeder #(.DEPTH(16), .GAP(2)) dut_a (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(a_wr_ready), .wr_x(wr_x), .wr_y(wr_y),
    .wr_last(wr_last), .enter(a_enter), .X(a_x), .Y(a_y), .busy(a_busy),
    .frames_pending(a_fp), .err(a_err)
  );

  matrixops_feeder #(.DEPTH(4), .GAP(1)) dut_b (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(b_wr_ready), .wr_x(wr_x), .wr_y(wr_y),
    .wr_last(wr_last), .enter(b_enter), .X(b_x), .Y(b_y), .busy(b_busy),
    .frames_pending(b_fp), .err(b_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] x, input logic [1:0] y, input logic l);
    wr_valid = 1'b1;
    wr_x     = x;
    wr_y     = y;
    wr_last  = l;
  endtask

  task automatic nowr();
    wr_valid = 1'b0;
    wr_x     = 2'd0;
    wr_y     = 2'd0;
    wr_last  = 1'b0;
  endtask

  task automatic do_reset();
    nowr();
    rst = 1'b0;
    cyc();
    cyc();
    rst = 1'b1;
  endtask

  initial begin
    fx = '{2'd0, 2'd2, 2'd1, 2'd1, 2'd1, 2'd3, 2'd0, 2'd1};
    fy = '{2'd0, 2'd0, 2'd1, 2'd3, 2'd3, 2'd3, 2'd2, 2'd1};
    px = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd3, 2'd1, 2'd2, 2'd0};
    py = '{2'd0, 2'd3, 2'd1, 2'd2, 2'd3, 2'd2, 2'd0, 2'd1};
    qx = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2};
    qy = '{2'd1, 2'd2, 2'd3, 2'd1, 2'd0, 2'd3};

    // Reset values
    cyc();
    chk("rst_enter", 32'(a_enter), 0);
    chk("rst_x", 32'(a_x), 0);
    chk("rst_y", 32'(a_y), 0);
    chk("rst_busy", 32'(a_busy), 0);
    chk("rst_fp", 32'(a_fp), 0);
    chk("rst_err", 32'(a_err), 0);
    chk("rst_wr_ready", 32'(a_wr_ready), 1);
    chk("rst_b_wr_ready", 32'(b_wr_ready), 1);
    rst = 1'b1;
    cyc();

    // Single-entry frame
    wr(2'd0, 2'd0, 1'b1);
    cyc();
    nowr();
    chk("t1_fp_after_write", 32'(a_fp), 1);
    chk("t1_enter_early", 32'(a_enter), 0);
    cyc();
    chk("t1_enter", 32'(a_enter), 1);
    chk("t1_x", 32'(a_x), 0);
    chk("t1_y", 32'(a_y), 0);
    chk("t1_busy_send", 32'(a_busy), 1);
    chk("t1_fp_started", 32'(a_fp), 0);
    cyc();
    chk("t1_gap1_enter", 32'(a_enter), 0);
    chk("t1_gap1_busy", 32'(a_busy), 1);
    cyc();
    chk("t1_gap2_enter", 32'(a_enter), 0);
    chk("t1_gap2_busy", 32'(a_busy), 1);
    cyc();
    chk("t1_idle_busy", 32'(a_busy), 0);
    chk("t1_idle_enter", 32'(a_enter), 0);

    // 8-pair frame; nothing may come out before its last pair is accepted
    for (int i = 0; i < 8; i++) begin
      wr(fx[i], fy[i], i == 7);
      cyc();
      chk($sformatf("t2_noearly_%0d", i), 32'(a_enter), 0);
    end
    // While it streams, pre-load [(1,2)L] and [(3,1),(2,2)L]
    for (int i = 0; i < 8; i++) begin
      case (i)
        0: wr(2'd1, 2'd2, 1'b1);
        1: wr(2'd3, 2'd1, 1'b0);
        2: wr(2'd2, 2'd2, 1'b1);
        default: nowr();
      endcase
      cyc();
      chk($sformatf("t2_enter_%0d", i), 32'(a_enter), 1);
      chk($sformatf("t2_x_%0d", i), 32'(a_x), 32'(fx[i]));
      chk($sformatf("t2_y_%0d", i), 32'(a_y), 32'(fy[i]));
    end
    chk("t3_fp_preloaded", 32'(a_fp), 2);
    cyc();
    chk("t3_gap_a1", 32'(a_enter), 0);
    cyc();
    chk("t3_gap_a2", 32'(a_enter), 0);
    chk("t3_fp2", 32'(a_fp), 2);
    cyc();
    chk("t3_f1_enter", 32'(a_enter), 1);
    chk("t3_f1_x", 32'(a_x), 1);
    chk("t3_f1_y", 32'(a_y), 2);
    chk("t3_fp1", 32'(a_fp), 1);
    cyc();
    chk("t3_gap_b1", 32'(a_enter), 0);
    cyc();
    chk("t3_gap_b2", 32'(a_enter), 0);
    cyc();
    chk("t3_f2a_enter", 32'(a_enter), 1);
    chk("t3_f2a_x", 32'(a_x), 3);
    chk("t3_f2a_y", 32'(a_y), 1);
    chk("t3_fp0", 32'(a_fp), 0);
    cyc();
    chk("t3_f2b_enter", 32'(a_enter), 1);
    chk("t3_f2b_x", 32'(a_x), 2);
    chk("t3_f2b_y", 32'(a_y), 2);
    cyc();
    chk("t3_after_enter", 32'(a_enter), 0);
    cyc();
    cyc();
    chk("t3_idle_busy", 32'(a_busy), 0);

    // Overflow on the DEPTH=4 instance: 5 pairs without last
    do_reset();
    for (int i = 0; i < 5; i++) begin
      wr(2'(i), 2'd1, 1'b0);
      cyc();
      if (i < 3) chk($sformatf("t4_ready_%0d", i), 32'(b_wr_ready), 1);
      if (i == 3) begin
        chk("t4_full_ready", 32'(b_wr_ready), 0);
        chk("t4_err_before", 32'(b_err), 0);
      end
      if (i == 4) begin
        chk("t4_err", 32'(b_err), 1);
        chk("t4_ready_flushed", 32'(b_wr_ready), 1);
        chk("t4_enter", 32'(b_enter), 0);
      end
    end
    nowr();
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk($sformatf("t4_no_pulse_%0d", i), 32'(b_enter), 0);
      chk($sformatf("t4_fp_%0d", i), 32'(b_fp), 0);
    end
    wr(2'd2, 2'd1, 1'b1);
    cyc();
    nowr();
    cyc();
    chk("t4_fresh_enter", 32'(b_enter), 1);
    chk("t4_fresh_x", 32'(b_x), 2);
    chk("t4_fresh_y", 32'(b_y), 1);
    chk("t4_err_sticky", 32'(b_err), 1);

    // Continuous writes while popping a full DEPTH=4 FIFO
    do_reset();
    for (int i = 0; i < 8; i++) begin
      wr(px[i], py[i], (i == 3) || (i == 7));
      cyc();
      if (i >= 3 && i < 7) chk($sformatf("t5_ready_%0d", i), 32'(b_wr_ready), 1);
      if (i == 7) chk("t5_ready_full", 32'(b_wr_ready), 0);
      if (i >= 4) begin
        chk($sformatf("t5_enter_%0d", i), 32'(b_enter), 1);
        chk($sformatf("t5_x_%0d", i), 32'(b_x), 32'(px[i-4]));
        chk($sformatf("t5_y_%0d", i), 32'(b_y), 32'(py[i-4]));
      end
    end
    nowr();
    cyc();
    chk("t5_gap", 32'(b_enter), 0);
    for (int j = 4; j < 8; j++) begin
      cyc();
      chk($sformatf("t5_f2_enter_%0d", j), 32'(b_enter), 1);
      chk($sformatf("t5_f2_x_%0d", j), 32'(b_x), 32'(px[j]));
      chk($sformatf("t5_f2_y_%0d", j), 32'(b_y), 32'(py[j]));
    end
    cyc();
    chk("t5_end_enter", 32'(b_enter), 0);
    chk("t5_err", 32'(b_err), 0);

    // Reset in the 3rd SEND cycle of a 6-pair frame, with another frame queued
    do_reset();
    for (int i = 0; i < 6; i++) begin
      wr(qx[i], qy[i], i == 5);
      cyc();
    end
    wr(2'd3, 2'd0, 1'b1);
    cyc();
    nowr();
    cyc();
    cyc();
    chk("t6_send3_enter", 32'(a_enter), 1);
    chk("t6_send3_x", 32'(a_x), 32'(qx[2]));
    chk("t6_fp_queued", 32'(a_fp), 1);
    rst = 1'b0;
    #1;
    chk("t6_async_enter", 32'(a_enter), 0);
    chk("t6_async_fp", 32'(a_fp), 0);
    chk("t6_async_busy", 32'(a_busy), 0);
    cyc();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk($sformatf("t6_residual_%0d", i), 32'(a_enter), 0);
    end
    wr(2'd3, 2'd2, 1'b1);
    cyc();
    nowr();
    cyc();
    chk("t6_new_enter", 32'(a_enter), 1);
    chk("t6_new_x", 32'(a_x), 3);
    chk("t6_new_y", 32'(a_y), 2);
    cyc();
    chk("t6_new_done", 32'(a_enter), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
